// File: rtl/hdmi_timing_gen_if.sv
// Video timing bus between the timing generator and its consumers.
// The consumer drives the run enable; the timing generator drives everything else.
interface hdmi_timing_gen_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9
);
  logic          en;
  logic          hsync;
  logic          vsync;
  logic          active_area;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic          pix_req;

  modport master (
    input  en,
    output hsync, vsync, active_area, x, y, line_start, frame_start, pix_req
  );

  modport slave (
    output en,
    input  hsync, vsync, active_area, x, y, line_start, frame_start, pix_req
  );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Free-running video timing generator with a look-ahead pixel request.
// A request counter pair runs LEAD positions ahead of the display counter pair.
module hdmi_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned LEAD     = 2
) (
  input logic               p_clk,
  input logic               resetn,
  hdmi_timing_gen_if.master vid
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);
  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = $clog2(V_ACTIVE);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] D_H_INIT  = HW'(H_TOTAL - LEAD);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] D_V_INIT  = V_LAST;

  logic [HW-1:0] rh_q, rh_d, dh_q, dh_d;
  logic [VW-1:0] rv_q, rv_d, dv_q, dv_d;

  logic          disp_active, req_active, in_hsync, in_vsync;
  logic          hsync_d, vsync_d, active_d, line_start_d, frame_start_d, pix_req_d;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;

  function automatic logic [HW-1:0] h_step(input logic [HW-1:0] h);
    return (h == H_LAST) ? '0 : h + HW'(1);
  endfunction

  function automatic logic [VW-1:0] v_step(input logic [HW-1:0] h, input logic [VW-1:0] v);
    if (h != H_LAST) return v;
    return (v == V_LAST) ? '0 : v + VW'(1);
  endfunction

  // Position decodes on the current counter values
  assign disp_active = (dh_q < H_ACT_END) && (dv_q < V_ACT_END);
  assign req_active  = (rh_q < H_ACT_END) && (rv_q < V_ACT_END);
  assign in_hsync    = (dh_q >= HS_START) && (dh_q < HS_END);
  assign in_vsync    = (dv_q >= VS_START) && (dv_q < VS_END);

  // Next counters and next outputs; a low enable forces the reset values
  always_comb begin
    rh_d          = '0;
    rv_d          = '0;
    dh_d          = D_H_INIT;
    dv_d          = D_V_INIT;
    hsync_d       = ~HS_POL;
    vsync_d       = ~VS_POL;
    active_d      = 1'b0;
    x_d           = '0;
    y_d           = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    pix_req_d     = 1'b0;
    if (vid.en) begin
      rh_d      = h_step(rh_q);
      rv_d      = v_step(rh_q, rv_q);
      dh_d      = h_step(dh_q);
      dv_d      = v_step(dh_q, dv_q);
      hsync_d   = in_hsync ? HS_POL : ~HS_POL;
      vsync_d   = in_vsync ? VS_POL : ~VS_POL;
      active_d  = disp_active;
      pix_req_d = req_active;
      if (disp_active) begin
        x_d           = XW'(dh_q);
        y_d           = YW'(dv_q);
        line_start_d  = (dh_q == '0);
        frame_start_d = (dh_q == '0) && (dv_q == '0);
      end
    end
  end

  always_ff @(posedge p_clk or negedge resetn) begin
    if (!resetn) begin
      rh_q            <= '0;
      rv_q            <= '0;
      dh_q            <= D_H_INIT;
      dv_q            <= D_V_INIT;
      vid.hsync       <= ~HS_POL;
      vid.vsync       <= ~VS_POL;
      vid.active_area <= 1'b0;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.pix_req     <= 1'b0;
    end else begin
      rh_q            <= rh_d;
      rv_q            <= rv_d;
      dh_q            <= dh_d;
      dv_q            <= dv_d;
      vid.hsync       <= hsync_d;
      vid.vsync       <= vsync_d;
      vid.active_area <= active_d;
      vid.x           <= x_d;
      vid.y           <= y_d;
      vid.line_start  <= line_start_d;
      vid.frame_start <= frame_start_d;
      vid.pix_req     <= pix_req_d;
    end
  end
endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen on a reduced 16x8 raster (8x4 visible), LEAD = 2, 1 and 5.
// Cycle n means n rising edges after reset release or enable rise.
module tb_hdmi_timing_gen;
  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  hdmi_timing_gen_if #(.XW(3), .YW(2)) vif2 ();
  hdmi_timing_gen_if #(.XW(3), .YW(2)) vif1 ();
  hdmi_timing_gen_if #(.XW(3), .YW(2)) vif5 ();

  hdmi_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .LEAD(2))
    u2 (.p_clk(clk), .resetn(resetn), .vid(vif2));
  hdmi_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .LEAD(1))
    u1 (.p_clk(clk), .resetn(resetn), .vid(vif1));
  hdmi_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .LEAD(5))
    u5 (.p_clk(clk), .resetn(resetn), .vid(vif5));

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [2:0] x;
    logic [1:0] y;
    logic       ls;
    logic       fs;
    logic       pr;
  } outs_t;

  typedef struct {
    int    t;
    outs_t e;
  } vec_t;

  vec_t     vecs[$];
  int       cyc;
  int       n_vec = 0;
  int       n_bad = 0;
  logic [7:0] hist1, hist5;

  function automatic vec_t mk(input int t, input bit hs, input bit vs, input bit act,
                              input int x, input int y, input bit ls, input bit fs, input bit pr);
    vec_t v;
    v.t = t;
    v.e = '{hs: hs, vs: vs, act: act, x: 3'(x), y: 2'(y), ls: ls, fs: fs, pr: pr};
    return v;
  endfunction

  function automatic outs_t sample2();
    outs_t o;
    o = '{hs: vif2.hsync, vs: vif2.vsync, act: vif2.active_area, x: vif2.x, y: vif2.y,
          ls: vif2.line_start, fs: vif2.frame_start, pr: vif2.pix_req};
    return o;
  endfunction

  // Advance one edge; the LEAD=1/5 request history is shifted every cycle
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    hist1 = {hist1[6:0], vif1.pix_req};
    hist5 = {hist5[6:0], vif5.pix_req};
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic cmp_vec(input string name, input vec_t v);
    outs_t g;
    g = sample2();
    n_vec++;
    if (g !== v.e) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got hs%b vs%b act%b x%0d y%0d ls%b fs%b pr%b exp hs%b vs%b act%b x%0d y%0d ls%b fs%b pr%b",
               name, cyc, g.hs, g.vs, g.act, g.x, g.y, g.ls, g.fs, g.pr,
               v.e.hs, v.e.vs, v.e.act, v.e.x, v.e.y, v.e.ls, v.e.fs, v.e.pr);
    end
  endtask

  task automatic run_table(input string name, input int maxt);
    foreach (vecs[i]) begin
      if (vecs[i].t <= maxt) begin
        while (cyc < vecs[i].t) tick();
        cmp_vec(name, vecs[i]);
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn = 1'b1;
    cyc    = 0;
    hist1  = '0;
    hist5  = '0;
  endtask

  int n_act, n_hs, n_vs, n_ls, n_fs, n_pr, max_x, max_y;
  int n_act1, n_pr1, n_act5, n_pr5;
  vec_t idle;

  initial begin
    //            t   hs vs act x  y  ls fs pr
    vecs.push_back(mk(0,   1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,   1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(2,   1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(3,   1, 1, 1, 0, 0, 1, 1, 1));
    vecs.push_back(mk(4,   1, 1, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(9,   1, 1, 1, 6, 0, 0, 0, 0));
    vecs.push_back(mk(10,  1, 1, 1, 7, 0, 0, 0, 0));
    vecs.push_back(mk(11,  1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(12,  1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(13,  0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(15,  0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(16,  1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(17,  1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(19,  1, 1, 1, 0, 1, 1, 0, 1));
    vecs.push_back(mk(20,  1, 1, 1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(58,  1, 1, 1, 7, 3, 0, 0, 0));
    vecs.push_back(mk(59,  1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(82,  1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(83,  1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(94,  0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(114, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(115, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(127, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(129, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(130, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(131, 1, 1, 1, 0, 0, 1, 1, 1));
    idle = mk(0, 1, 1, 0, 0, 0, 0, 0, 0);

    resetn   = 1'b0;
    vif2.en  = 1'b1;
    vif1.en  = 1'b1;
    vif5.en  = 1'b1;
    cyc      = 0;
    hist1    = '0;
    hist5    = '0;
    repeat (3) @(posedge clk);
    release_reset();
    run_table("t1_table", 1000);

    // Two frames: frame statistics on LEAD=2, look-ahead scoreboards on LEAD=1 and LEAD=5
    n_act = 0; n_hs = 0; n_vs = 0; n_ls = 0; n_fs = 0; n_pr = 0; max_x = 0; max_y = 0;
    n_act1 = 0; n_pr1 = 0; n_act5 = 0; n_pr5 = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i < 128) begin
        n_act += int'(vif2.active_area);
        n_hs  += int'(!vif2.hsync);
        n_vs  += int'(!vif2.vsync);
        n_ls  += int'(vif2.line_start);
        n_fs  += int'(vif2.frame_start);
        n_pr  += int'(vif2.pix_req);
        if (int'(vif2.x) > max_x) max_x = int'(vif2.x);
        if (int'(vif2.y) > max_y) max_y = int'(vif2.y);
      end
      n_act1 += int'(vif1.active_area);
      n_pr1  += int'(vif1.pix_req);
      n_act5 += int'(vif5.active_area);
      n_pr5  += int'(vif5.pix_req);
      chk("sb_lead1", int'(vif1.active_area), int'(hist1[1]));
      chk("sb_lead5", int'(vif5.active_area), int'(hist5[5]));
    end
    chk("active_per_frame", n_act, 32);
    chk("hsync_per_frame", n_hs, 24);
    chk("vsync_per_frame", n_vs, 32);
    chk("line_start_per_frame", n_ls, 4);
    chk("frame_start_per_frame", n_fs, 1);
    chk("pix_req_per_frame", n_pr, 32);
    chk("max_x", max_x, 7);
    chk("max_y", max_y, 3);
    chk("lead1_active_2frames", n_act1, 64);
    chk("lead1_req_2frames", n_pr1, 64);
    chk("lead5_active_2frames", n_act5, 64);
    chk("lead5_req_2frames", n_pr5, 64);

    // Enable drop at display pixel (5,2), held low for three edges
    while (cyc < 424) tick();
    cmp_vec("t5_at_pixel", mk(424, 1, 1, 1, 5, 2, 0, 0, 1));
    vif2.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp_vec("t5_idle", idle);
    end
    vif2.en = 1'b1;
    cyc     = 0;
    run_table("t5_restart", 20);

    // Asynchronous reset at display pixel (4,1), checked before the next edge
    while (cyc < 23) tick();
    cmp_vec("t6_at_pixel", mk(23, 1, 1, 1, 4, 1, 0, 0, 1));
    #2;
    resetn = 1'b0;
    #1;
    cmp_vec("t6_async_reset", idle);
    repeat (2) @(posedge clk);
    release_reset();
    run_table("t6_restart", 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
